// File: rtl/axi_lite_multi_read_fifo_if.sv
// axi_lite_multi_read_fifo_if: AXI-Lite read address and read data channels
interface axi_lite_multi_read_fifo_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH = 32
);
  logic arready;
  logic arvalid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic rready;
  logic rvalid;
  logic [BUS_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  modport slave(output arready, rvalid, rdata, rresp, input arvalid, araddr, rready);
  modport master(input arready, rvalid, rdata, rresp, output arvalid, araddr, rready);
endinterface

// File: rtl/axi_lite_multi_read_fifo.sv
// axi_lite_multi_read_fifo: per-channel stream FIFOs read back through an AXI-Lite read-only register map
module axi_lite_multi_read_fifo #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int BUS_WIDTH = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic reset,
  output logic [CHANNELS-1:0] ready_in,
  input logic [CHANNELS-1:0] valid_in,
  input logic [CHANNELS*BUS_WIDTH-1:0] data_in,
  axi_lite_multi_read_fifo_if.slave s_axi
);
  localparam int AW = $clog2(BUS_WIDTH/8);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic {IDLE, RESP} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] off, idx;
  logic mapped, ar_hs;
  logic [SW-1:0] sel;
  logic [CHANNELS-1:0] push, pop, full, empty;
  logic [CHANNELS-1:0][CW-1:0] count;
  logic [CHANNELS-1:0][BUS_WIDTH-1:0] head;
  logic [BUS_WIDTH-1:0] status, rdata_n;
  logic [1:0] rresp_n;
  assign off = s_axi.araddr - BASE_ADDR;
  assign idx = off >> AW;
  assign mapped = s_axi.araddr >= BASE_ADDR && idx < ADDR_WIDTH'(2 * CHANNELS);
  assign sel = SW'(idx >> 1);
  assign ar_hs = s_axi.arvalid && s_axi.arready;
  // response for the address currently presented, taken from pre-edge FIFO state
  always_comb begin
    status = '0;
    status[CW-1:0] = count[sel];
    status[BUS_WIDTH-1] = empty[sel];
    status[BUS_WIDTH-2] = full[sel];
    rdata_n = !mapped ? '0 : idx[0] ? status : empty[sel] ? '0 : head[sel];
    rresp_n = !mapped ? 2'b11 : idx[0] ? 2'b00 : empty[sel] ? 2'b10 : 2'b00;
  end
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [BUS_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    assign full[c] = cnt == CW'(DEPTH);
    assign empty[c] = cnt == '0;
    assign ready_in[c] = !full[c];
    assign push[c] = valid_in[c] && !full[c];
    assign pop[c] = ar_hs && mapped && !idx[0] && sel == SW'(c) && !empty[c];
    assign count[c] = cnt;
    assign head[c] = mem[rd_ptr];
    // storage needs no reset: stale entries are never visible because count gates every read
    always_ff @(posedge clk)
      if (push[c]) mem[wr_ptr] <= data_in[c*BUS_WIDTH +: BUS_WIDTH];
    // pointers wrap naturally; count carries the extra bit that tells full from empty
    always_ff @(posedge clk)
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
      end else begin
        if (push[c]) wr_ptr <= wr_ptr + PW'(1);
        if (pop[c]) rd_ptr <= rd_ptr + PW'(1);
        cnt <= cnt + CW'(push[c]) - CW'(pop[c]);
      end
  end
  // one outstanding read: capture the response on AR, hold it until R completes
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      s_axi.arready <= 1'b1;
      s_axi.rvalid <= 1'b0;
      s_axi.rdata <= '0;
      s_axi.rresp <= 2'b00;
    end else
      case (state)
        IDLE:
          if (s_axi.arvalid) begin
            state <= RESP;
            s_axi.arready <= 1'b0;
            s_axi.rvalid <= 1'b1;
            s_axi.rdata <= rdata_n;
            s_axi.rresp <= rresp_n;
          end
        RESP:
          if (s_axi.rready) begin
            state <= IDLE;
            s_axi.arready <= 1'b1;
            s_axi.rvalid <= 1'b0;
          end
      endcase
endmodule

// File: tb/tb_axi_lite_multi_read_fifo.sv
// tb_axi_lite_multi_read_fifo: queue-model scoreboard bench for the multi-channel read FIFO slave
module tb_axi_lite_multi_read_fifo;
  localparam int AW = 32;
  localparam int BW = 32;
  localparam int CH = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h0000_0100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [CH-1:0] ready_in;
  logic [CH-1:0] valid_in = '0;
  logic [CH*BW-1:0] data_in = '0;
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] q[CH][$];
  logic [BW+1:0] sb[$];
  bit busy = 0;
  bit rdy[CH];
  bit took = 0;
  axi_lite_multi_read_fifo_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW)) axi();
  axi_lite_multi_read_fifo #(
    .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .BUS_WIDTH(BW), .CHANNELS(CH), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .ready_in(ready_in), .valid_in(valid_in), .data_in(data_in), .s_axi(axi)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // reference read: register map semantics on plain queues
  function automatic logic [BW+1:0] model_read(input logic [31:0] a);
    int unsigned idx, c, n;
    logic [31:0] st;
    if (a < BASE) return {32'h0, 2'b11};
    idx = (a - BASE) / 4;
    if (idx >= 2 * CH) return {32'h0, 2'b11};
    c = idx / 2;
    n = q[c].size();
    if (idx % 2 == 1) begin
      st = n;
      if (n == 0) st += 32'h8000_0000;
      if (n == DEPTH) st += 32'h4000_0000;
      return {st, 2'b00};
    end
    if (n == 0) return {32'h0, 2'b10};
    return {q[c].pop_front(), 2'b00};
  endfunction
  // reference model: advances one clock per falling edge using the inputs about to be sampled
  always @(negedge clk) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) q[c].delete();
      sb.delete();
      busy = 0;
    end else begin
      chk("arready", axi.arready, !busy);
      chk("rvalid", axi.rvalid, busy);
      for (int c = 0; c < CH; c++) begin
        rdy[c] = q[c].size() < DEPTH;
        chk($sformatf("ready_in[%0d]", c), ready_in[c], rdy[c]);
      end
      if (busy) begin
        if (axi.rready) busy = 0;
      end else if (axi.arvalid) begin
        sb.push_back(model_read(axi.araddr));
        busy = 1;
      end
      for (int c = 0; c < CH; c++)
        if (valid_in[c] && rdy[c]) q[c].push_back(data_in[c*BW +: BW]);
    end
  end
  // monitor: every cycle a response is presented it must equal the oldest expected one
  always @(negedge clk)
    if (!reset && axi.rvalid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid: response presented with no read outstanding at %0t", $time);
      end else begin
        chk("rresp", axi.rresp, sb[0][1:0]);
        chk("rdata", axi.rdata, sb[0][BW+1:2]);
        if (axi.rready) void'(sb.pop_front());
      end
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [31:0] a);
    int n = 0;
    axi.arvalid = 1'b1;
    axi.araddr = a;
    @(negedge clk);
    while (!axi.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL ar_timeout: addr %0h never accepted", a);
    end
    cyc();
    axi.arvalid = 1'b0;
  endtask
  task automatic wr(input int c, input logic [31:0] d);
    int n = 0;
    valid_in[c] = 1'b1;
    data_in[c*BW +: BW] = d;
    @(negedge clk);
    while (!ready_in[c] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: channel %0d never ready", c);
    end
    cyc();
    valid_in[c] = 1'b0;
  endtask
  function automatic logic [31:0] raddr();
    int unsigned k = $urandom_range(0, 11);
    if (k == 11) return BASE - 32'd4;
    return BASE + k * 4 + $urandom_range(0, 3);
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    axi.arvalid = 1'b0;
    axi.araddr = '0;
    axi.rready = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_rdata", axi.rdata, 0);
    chk("reset_rresp", axi.rresp, 0);
    chk("reset_arready", axi.arready, 1);
    cyc();
    rd(BASE + 4);
    rd(BASE + 2 * CH * 4);
    rd(BASE - 4);
    for (int i = 0; i < 8; i++) wr(1, 32'h10 + i);
    rd(BASE + 3 * 4);
    for (int i = 0; i < 9; i++) rd(BASE + 2 * 4);
    rd(BASE + 3 * 4);
    for (int i = 0; i < 3; i++) wr(0, 32'hA0 + i);
    valid_in[0] = 1'b1;
    data_in[0 +: BW] = 32'hA3;
    rd(BASE);
    valid_in[0] = 1'b0;
    rd(BASE + 4);
    wr(2, 32'hC0);
    wr(2, 32'hC1);
    axi.rready = 1'b0;
    rd(BASE + 4 * 4);
    for (int i = 0; i < 5; i++) wr(2, 32'hC2 + i);
    axi.rready = 1'b1;
    rd(BASE + 4 * 4);
    rd(BASE + 5 * 4);
    for (int i = 0; i < 20; i++) begin
      wr(3, 32'h300 + i);
      if (i >= 2) rd(BASE + 6 * 4);
    end
    repeat (3) rd(BASE + 6 * 4);
    wr(1, 32'hDD);
    axi.rready = 1'b0;
    rd(BASE + 2 * 4);
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    axi.rready = 1'b1;
    for (int c = 0; c < CH; c++) rd(BASE + (2 * c + 1) * 4);
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < CH; c++) begin
        valid_in[c] = $urandom_range(0, 5) == 0;
        data_in[c*BW +: BW] = $urandom;
      end
      axi.rready = $urandom_range(0, 3) != 0;
      if (!axi.arvalid || took) begin
        axi.arvalid = $urandom_range(0, 2) == 0;
        axi.araddr = raddr();
      end
      @(negedge clk);
      took = axi.arvalid && axi.arready;
      cyc();
    end
    axi.arvalid = 1'b0;
    valid_in = '0;
    axi.rready = 1'b1;
    repeat (5) cyc();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_lite_multi_read_fifo.md
# axi_lite_multi_read_fifo

Multi-channel AXI-Lite read-only FIFO slave. Collects words from CHANNELS independent valid/ready producers into per-channel FIFOs and exposes each FIFO as a pop-on-read data register plus a status register on a shared AXI-Lite read port. It sits between streaming producers and a host CPU that polls for results. Reads are non-blocking: an empty FIFO returns SLVERR, and an unmapped address returns DECERR.

## Interface
- BASE_ADDR, 'h0000_0000: byte address of register 0. Must be aligned to BUS_WIDTH/8.
- ADDR_WIDTH, 32: AXI address width.
- BUS_WIDTH, 32: data width. Must be a power of two ≥ 8 and ≥ CW+2, where CW = $clog2(DEPTH)+1.
- CHANNELS, 4: number of FIFOs, ≥ 1.
- DEPTH, 8: entries per FIFO. Power of two, ≥ 2. All DEPTH entries are usable.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ready_in  out  CHANNELS  per-channel producer ready; bit c = ~full[c].
- valid_in  in  CHANNELS  per-channel producer valid.
- data_in  in  CHANNELS*BUS_WIDTH  channel c occupies bits [c*BUS_WIDTH +: BUS_WIDTH].
- s_axi_arready  out  1  read address ready.
- s_axi_arvalid  in  1  read address valid.
- s_axi_araddr  in  ADDR_WIDTH  read byte address.
- s_axi_rready  in  1  read data ready.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rdata  out  BUS_WIDTH  read data (registered).
- s_axi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR (registered).

## Operation
- **Address map.** W = BUS_WIDTH/8. idx = (araddr − BASE_ADDR) >> $clog2(W); the low address bits are ignored. Even idx 2c is DATA[c]; odd idx 2c+1 is STATUS[c].
- **Decode.** An address is mapped iff araddr ≥ BASE_ADDR and idx < 2*CHANNELS. Otherwise the response is DECERR with rdata 0.
- **DATA[c].**
  - FIFO non-empty: rdata = head entry, rresp OKAY, and the entry is popped in the AR handshake cycle.
  - FIFO empty: rdata 0, rresp SLVERR, no pop, no state change.
- **STATUS[c].** rdata[CW-1:0] = count; rdata[BUS_WIDTH-1] = empty; rdata[BUS_WIDTH-2] = full; all other bits 0; rresp OKAY. No side effects.
- **FIFO per channel.**
  - Write when valid_in[c] && ready_in[c].
  - Pointers are $clog2(DEPTH) bits and wrap naturally. count is CW bits, range 0..DEPTH.
  - full = (count == DEPTH); empty = (count == 0).
  - Simultaneous write and pop on the same channel: both occur and count is unchanged.
  - ready_in does not account for a same-cycle pop: a full FIFO deasserts ready_in even if it is being popped that cycle.
- **State machine.**
  - IDLE: arready = 1. On arvalid, capture rdata/rresp from current-cycle state (count and head as they were before any same-cycle write), perform any pop, go to RESP.
  - RESP: arready = 0, rvalid = 1, rdata/rresp held stable. On rready go to IDLE.
- **Reset values.** state IDLE, all pointers and counts 0, rvalid 0, rdata 0, rresp 00, arready 1 in the first cycle after reset deasserts, ready_in all 1.
- **Reset mid-operation.** Reset in RESP drops rvalid the next cycle and the response is lost. Reset discards all FIFO contents.

## Timing
- AR handshake in cycle T gives rvalid = 1 in T+1.
- R handshake in cycle T+k returns the block to IDLE, with arready = 1 at T+k+1. Peak rate is one read per 2 cycles.
- Pop effect: count decrements and ready_in reasserts at T+1.
- Producer write in cycle T: the entry is readable via an AR handshake at T+1 or later, and count is visible to STATUS at T+1 or later.
- rdata/rresp do not change while rvalid = 1 and rready = 0, regardless of FIFO activity.

## Test plan
- **Reset and map.** Reset, then read STATUS[0] -> rdata = {empty=1, full=0, count=0}, OKAY. Read idx 2*CHANNELS -> DECERR, rdata 0. Read BASE_ADDR−W -> DECERR.
- **Fill and drain (ch1, DEPTH=8).** Push 0x10..0x17 -> ready_in[1] = 0 after the 8th, and STATUS[1] shows count 8, full=1. Eight DATA[1] reads -> 0x10..0x17 in order, OKAY. A ninth read -> SLVERR, rdata 0, count stays 0.
- **Simultaneous write/pop.** FIFO ch0 holds 3 entries; issue a DATA[0] AR handshake in the same cycle as a write -> count stays 3, and the head returned is the oldest entry.
- **R back-pressure.** Hold rready = 0 for 5 cycles while ch2 receives writes -> rvalid, rdata and rresp stay stable; arready = 0; the next read returns the correct following entry.
- **Pointer wrap.** Stream 20 words through ch3 with interleaved reads (occupancy ≤ 3) -> all 20 are returned in order with no loss or duplication.
- **Reset mid-operation.** Assert reset while in RESP -> rvalid = 0 the next cycle, all counts 0, arready = 1 after deassertion.
